// File: rtl/vga_sync_ctrl_if.sv
// Raster timing bundle from the VGA sync controller to the pixel generator.
interface vga_sync_ctrl_if;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
    logic       blink_on;

    modport master (
        output hsync,
        output vsync,
        output video_on,
        output pixel_x,
        output pixel_y,
        output frame_start,
        output blink_on
    );

    modport slave (
        input hsync,
        input vsync,
        input video_on,
        input pixel_x,
        input pixel_y,
        input frame_start,
        input blink_on
    );
endinterface

// File: rtl/vga_sync_ctrl.sv
// 640x480@60 raster sequencer paced by pixel_rate edges in the CLK_NX domain,
// with ring-blink gating latched only at frame boundaries.
module vga_sync_ctrl #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input  logic CLK_NX,
    input  logic reset,
    input  logic pixel_rate,
    input  logic clk_RING,
    input  logic ring_en,
    vga_sync_ctrl_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SY   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BP   = 10'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SY   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BP   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam logic [1:0] S_ACTIVE = 2'd0;
    localparam logic [1:0] S_FRONT  = 2'd1;
    localparam logic [1:0] S_SYNC   = 2'd2;
    localparam logic [1:0] S_BACK   = 2'd3;

    logic       rate_q;
    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    logic [1:0] hst_q, hst_d;
    logic [1:0] vst_q, vst_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       video_q, video_d;
    logic       fs_q, fs_d;
    logic       blink_q, blink_d;

    logic pix_tick;
    logic h_wrap;
    logic v_wrap;

    assign pix_tick = pixel_rate & ~rate_q;
    assign h_wrap   = (h_q == H_LAST);
    assign v_wrap   = (v_q == V_LAST);

    always_comb begin
        h_d   = h_q;
        v_d   = v_q;
        hst_d = hst_q;
        vst_d = vst_q;
        if (pix_tick) begin
            h_d = h_wrap ? 10'd0 : h_q + 10'd1;
            unique case (hst_q)
                S_ACTIVE: if (h_d == H_FP) hst_d = S_FRONT;
                S_FRONT:  if (h_d == H_SY) hst_d = S_SYNC;
                S_SYNC:   if (h_d == H_BP) hst_d = S_BACK;
                S_BACK:   if (h_d == 10'd0) hst_d = S_ACTIVE;
                default:  hst_d = S_BACK;
            endcase
            // vertical state only moves on the line wrap
            if (h_wrap) begin
                v_d = v_wrap ? 10'd0 : v_q + 10'd1;
                unique case (vst_q)
                    S_ACTIVE: if (v_d == V_FP) vst_d = S_FRONT;
                    S_FRONT:  if (v_d == V_SY) vst_d = S_SYNC;
                    S_SYNC:   if (v_d == V_BP) vst_d = S_BACK;
                    S_BACK:   if (v_d == 10'd0) vst_d = S_ACTIVE;
                    default:  vst_d = S_BACK;
                endcase
            end
        end
    end

    always_comb begin
        hsync_d = (hst_d == S_SYNC) ? SYNC_POL : ~SYNC_POL;
        vsync_d = (vst_d == S_SYNC) ? SYNC_POL : ~SYNC_POL;
        video_d = (hst_d == S_ACTIVE) && (vst_d == S_ACTIVE);
        fs_d    = pix_tick & h_wrap & v_wrap;
        blink_d = blink_q;
        if (fs_d) begin
            blink_d = ring_en ? clk_RING : 1'b1;
        end
    end

    always_ff @(posedge CLK_NX or posedge reset) begin
        if (reset) begin
            rate_q  <= 1'b0;
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            hst_q   <= S_BACK;
            vst_q   <= S_BACK;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            video_q <= 1'b0;
            fs_q    <= 1'b0;
            blink_q <= 1'b1;
        end else begin
            rate_q  <= pixel_rate;
            h_q     <= h_d;
            v_q     <= v_d;
            hst_q   <= hst_d;
            vst_q   <= vst_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            fs_q    <= fs_d;
            blink_q <= blink_d;
        end
    end

    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_q;
    assign vga.pixel_x     = h_q;
    assign vga.pixel_y     = v_q;
    assign vga.frame_start = fs_q;
    assign vga.blink_on    = blink_q;

endmodule
